// File: rtl/ex_div_pkg.sv
// Shared definitions for the EX-stage iterative divider: ALU op codes, FSM states, sizing.
package ex_div_pkg;

  localparam int WORD_WIDTH        = 32;
  localparam int DATA_WIDTH_ALU_OP = 5;
  localparam int DIV_ITER          = 32;
  localparam int DIV_CNT_W         = 5;

  localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_ADD  = 5'd0;
  localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_DIV  = 5'd16;
  localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_DIVU = 5'd17;
  localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_REM  = 5'd18;
  localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_REMU = 5'd19;

  typedef enum logic [1:0] {
    DIV_ST_IDLE = 2'b00,
    DIV_ST_CALC = 2'b01,
    DIV_ST_DONE = 2'b10
  } div_state_e;

  function automatic logic is_div_op(input logic [DATA_WIDTH_ALU_OP-1:0] op);
    return (op == ALU_OP_DIV) || (op == ALU_OP_DIVU) || (op == ALU_OP_REM) || (op == ALU_OP_REMU);
  endfunction

  function automatic logic is_rem_op(input logic [DATA_WIDTH_ALU_OP-1:0] op);
    return (op == ALU_OP_REM) || (op == ALU_OP_REMU);
  endfunction

  function automatic logic is_signed_op(input logic [DATA_WIDTH_ALU_OP-1:0] op);
    return (op == ALU_OP_DIV) || (op == ALU_OP_REM);
  endfunction

endpackage

// File: rtl/ex_div_if.sv
// ID/EX-to-divider handshake: registered op/operands in, stall/done/result out.
interface ex_div_if;
  import ex_div_pkg::*;

  logic                         id_en;
  logic [DATA_WIDTH_ALU_OP-1:0] id_alu_op;
  logic [WORD_WIDTH-1:0]        id_alu_in_0;
  logic [WORD_WIDTH-1:0]        id_alu_in_1;
  logic                         rem_after_div;
  logic                         div_stall;
  logic                         div_done;
  logic [WORD_WIDTH-1:0]        div_result;

  modport master (
    output id_en, id_alu_op, id_alu_in_0, id_alu_in_1, rem_after_div,
    input  div_stall, div_done, div_result
  );

  modport slave (
    input  id_en, id_alu_op, id_alu_in_0, id_alu_in_1, rem_after_div,
    output div_stall, div_done, div_result
  );
endinterface

// File: rtl/ex_div_step.sv
// One restoring division iteration: shift in the next dividend bit, trial-subtract, emit quotient bit.
module ex_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN+1:0] shifted;
  logic            ge;

  // The partial remainder stays below the divisor, so the top bit of rem_in is always zero.
  assign shifted = {rem_in, quo_in[XLEN-1]};
  assign ge      = shifted >= {2'b00, divisor};
  assign rem_out = ge ? (XLEN+1)'(shifted - {2'b00, divisor}) : (XLEN+1)'(shifted);
  assign quo_out = {quo_in[XLEN-2:0], ge};

endmodule

// File: rtl/ex_div.sv
// Iterative radix-2 DIV/DIVU/REM/REMU unit with a one-entry remainder cache for REM-after-DIV.
// Optional macro EX_DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
module ex_div
  import ex_div_pkg::*;
#(
  parameter int XLEN  = WORD_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     cpu_en,
  input  logic     ex_flush,
  ex_div_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_ITER - 1);

  div_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN:0]   rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] div_q;
  logic            neg_quo_q, neg_rem_q, op_rem_q, rad_q;
  logic [XLEN-1:0] div_result_q;
  logic [XLEN-1:0] cache_rem_q;
  logic            cache_valid_q, rem_pending_q;

  logic [XLEN:0]   step_rem;
  logic [XLEN-1:0] step_quo;
  logic            is_div, op_rem, op_signed, cache_hit;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] abs_a, abs_b;
  logic [XLEN-1:0] quo_res, rem_res, done_res;

  ex_div_step #(.XLEN(XLEN)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (div_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  assign op_rem    = is_rem_op(bus.id_alu_op);
  assign op_signed = is_signed_op(bus.id_alu_op);
  assign is_div    = bus.id_en && is_div_op(bus.id_alu_op);
  assign cache_hit = (state == DIV_ST_IDLE) && rem_pending_q && cache_valid_q && bus.id_en && op_rem;

  assign a_neg = op_signed && bus.id_alu_in_0[XLEN-1];
  assign b_neg = op_signed && bus.id_alu_in_1[XLEN-1];
  assign abs_a = a_neg ? -bus.id_alu_in_0 : bus.id_alu_in_0;
  assign abs_b = b_neg ? -bus.id_alu_in_1 : bus.id_alu_in_1;

  assign quo_res  = neg_quo_q ? -quo_q : quo_q;
  assign rem_res  = neg_rem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
  assign done_res = op_rem_q ? rem_res : quo_res;

  // NOTE: every output gets a default before the branches so no latch is inferred.
  always_comb begin
    bus.div_result = div_result_q;
    bus.div_done   = 1'b0;
    bus.div_stall  = 1'b0;
    if (state == DIV_ST_DONE) begin
      bus.div_result = done_res;
      bus.div_done   = !ex_flush;
    end else if (cache_hit) begin
      bus.div_result = cache_rem_q;
      bus.div_done   = !ex_flush;
    end else if ((state == DIV_ST_CALC) || is_div) begin
      bus.div_stall  = !ex_flush;
    end
  end

  // NOTE: only control state is reset; the datapath registers are always written before use.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= DIV_ST_IDLE;
      cnt           <= '0;
      div_result_q  <= '0;
      cache_valid_q <= 1'b0;
      rem_pending_q <= 1'b0;
    end else if (ex_flush) begin
      state         <= DIV_ST_IDLE;
      cache_valid_q <= 1'b0;
      rem_pending_q <= 1'b0;
    end else if (cpu_en) begin
      unique case (state)
        DIV_ST_IDLE: begin
          if (bus.id_en && !op_rem) rem_pending_q <= 1'b0;
          if (cache_hit) begin
            rem_pending_q <= 1'b0;
            div_result_q  <= cache_rem_q;
          end else if (is_div) begin
            op_rem_q  <= op_rem;
            rad_q     <= bus.rem_after_div && !op_rem;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            state     <= DIV_ST_DONE;
            if (bus.id_alu_in_1 == '0) begin
              quo_q <= '1;
              rem_q <= {1'b0, bus.id_alu_in_0};
            end else if (op_signed && (bus.id_alu_in_0 == {1'b1, {(XLEN-1){1'b0}}}) &&
                         (bus.id_alu_in_1 == '1)) begin
              quo_q <= {1'b1, {(XLEN-1){1'b0}}};
              rem_q <= '0;
`ifdef EX_DIV_EARLY_OUT_EN
            end else if (abs_a < abs_b) begin
              quo_q <= '0;
              rem_q <= {1'b0, bus.id_alu_in_0};
`endif
            end else begin
              quo_q     <= abs_a;
              rem_q     <= '0;
              div_q     <= abs_b;
              neg_quo_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
              cnt       <= '0;
              state     <= DIV_ST_CALC;
            end
          end
        end
        DIV_ST_CALC: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_CNT) state <= DIV_ST_DONE;
        end
        DIV_ST_DONE: begin
          div_result_q  <= done_res;
          cache_rem_q   <= rem_res;
          cache_valid_q <= 1'b1;
          rem_pending_q <= rad_q;
          state         <= DIV_ST_IDLE;
        end
        default: state <= DIV_ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ex_div.md
Name: ex_div

Overview:
- Iterative radix-2 divider in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the registered ALU op and operands for DIV/DIVU/REM/REMU and produces a 32-bit result.
- Holds ID/EX and upstream stages via a stall request while iterating.
- Caches the last quotient/remainder pair so a REM(U) flagged as rem_after_div completes with zero iteration cycles.

Parameters:
- XLEN, 32, operand/result width (must equal WORD_WIDTH).
- CNT_W, 5, iteration counter width, log2(XLEN).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cpu_en  in  1  global enable; when low all state freezes.
- ex_flush  in  1  kill in-flight op.
- id_en  in  1  ID/EX entry valid.
- id_alu_op  in  DATA_WIDTH_ALU_OP  ALU op code from ID/EX.
- id_alu_in_0  in  XLEN  dividend.
- id_alu_in_1  in  XLEN  divisor.
- rem_after_div  in  1  ID/EX holds DIV(U) and decode holds REM(U) with identical source registers.
- div_stall  out  1  hold ID/EX and upstream stages.
- div_done  out  1  one-cycle result-valid strobe.
- div_result  out  XLEN  quotient or remainder per op.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, counter=0, div_done=0, div_result=0, div_stall=0, cache_valid=0, rem_pending=0.
- is_div = id_en && op in {ALU_OP_DIV, ALU_OP_DIVU, ALU_OP_REM, ALU_OP_REMU}. Signed ops are DIV and REM.
- IDLE, case cache hit: if rem_pending && cache_valid && op is REM(U), then div_result = cached remainder and div_done=1 in the same cycle. No stall. rem_pending clears.
- IDLE, otherwise: if is_div, div_stall=1 combinationally in that cycle, and operands are latched.
- Divisor==0: next state DONE. Quotient=all ones; remainder=dividend.
- Signed overflow (0x8000_0000 / 0xFFFF_FFFF): next state DONE. Quotient=0x8000_0000; remainder=0.
- Else: store absolute values (signed ops) and sign flags, counter=0, next state CALC.
- CALC: one restoring step per cycle, MSB first. Partial remainder is XLEN+1 bits. div_stall=1. At counter==XLEN-1, next state DONE.
- DONE: apply signs. Quotient is negated when the operand signs differ (signed op); remainder takes the dividend sign.
- DONE outputs: div_result = quotient or remainder per op, div_done=1, div_stall=0 so the pipeline advances this cycle.
- DONE cache update: cache both values; cache_valid=1; rem_pending = registered rem_after_div for a DIV(U). Next state IDLE.
- Latency: normal op accepted at cycle T, result at T+33. Special cases at T+1. Cache hit at T+0.
- cpu_en=0: no state, counter or cache change. Outputs hold their values.
- ex_flush (priority over everything except rst): state=IDLE, div_done=0, rem_pending=0, cache_valid=0.
- Cache invalidation: any non-REM valid instruction entering from IDLE clears rem_pending. cache_valid is kept.
- div_result outside a done cycle holds its last value; consumers must qualify it with div_done.

Optional Feature:
- Macro: EX_DIV_EARLY_OUT_EN.
- Defined: in IDLE, if |dividend| < |divisor| (after abs), skip CALC and go to DONE with quotient=0 and remainder=dividend. Latency is T+1.
- Not defined: every nonspecial op takes the full 33 cycles.

Decomposition:
- Shared define file holds:
  - ALU_OP_DIV/DIVU/REM/REMU codes (existing).
  - New DIV_ST_IDLE/CALC/DONE 2-bit state encodings.
  - DIV_ITER constant (32).
- One natural sub-module: ex_div_step, a combinational single restoring iteration (partial remainder, quotient shift, next bit). Reusable if the divider is later unrolled to radix-4.

Test Plan:
- DIV 100/7 at T → div_stall high T..T+32; div_done at T+33; result 14.
- DIV 100/7 with rem_after_div=1, then REM same regs next cycle → result 2, div_done same cycle, no stall.
- DIV -7/2 = 0xFFFF_FFFD and REM -7/2 = 0xFFFF_FFFF. DIVU 0xFFFF_FFF9/2 = 0x7FFF_FFFC.
- DIV x/0 → 0xFFFF_FFFF at T+1. REMU 5/0 → 5. DIV 0x8000_0000/-1 → 0x8000_0000; REM of same → 0.
- ex_flush at counter=10 → state IDLE next cycle, no div_done. A following REM is not served from the cache.
- cpu_en low for 5 cycles mid-CALC → completion shifts by exactly 5 cycles. With EX_DIV_EARLY_OUT_EN, DIVU 3/9 → 0 at T+1.
